pkt_port_event_gen: RTL and testbench
=====================================

# pkt_port_event_gen

Upstream front-end for the per-second inter-arrival-time statistics stage. The block passively taps the datapath AXI4-Stream, detects each packet's first beat, and decodes the source port from TUSER. It emits a one-cycle port-event code on `proc_port_3rd` plus the free-running 1-second timebase `cnt_time`, both consumed by the IAT counter stage. It also guarantees that no event is presented in the cycle where the timebase hits its terminal value, so that cycle can be used exclusively for the per-second snapshot.

## Interface
- `C_TUSER_WIDTH`, 128, width of the tapped TUSER bus.
- `SRC_PORT_POS`, 16, bit offset of the 8-bit one-hot source-port field in TUSER.
- `TICKS_PER_SEC`, 160000000, terminal count of the timebase; must fit in 28 bits.
- `asclk`  in  1  datapath clock.
- `aresetn`  in  1  asynchronous, active-low reset.
- `s_axis_tvalid`  in  1  tapped stream valid.
- `s_axis_tready`  in  1  tapped stream ready; observed only, never driven.
- `s_axis_tlast`  in  1  tapped stream last beat.
- `s_axis_tuser`  in  C_TUSER_WIDTH  tapped sideband; source port is `tuser[SRC_PORT_POS+7:SRC_PORT_POS]`.
- `cnt_time`  out  28  timebase, runs 1..TICKS_PER_SEC.
- `proc_port_3rd`  out  3  event code:
  - 0–3: MAC port SOP.
  - 4: DMA-port SOP.
  - 5: illegal source field.
  - 7: no event.
- `bad_port_cnt`  out  32  saturating count of SOPs with an illegal source field.
- `evt_drop_cnt`  out  32  saturating count of events lost to skid overflow.

## Operation
- **Beat:** a beat is accepted when `s_axis_tvalid & s_axis_tready`. No other signal qualifies a beat.
- **SOP FSM:** two states, `WAIT_SOP` and `IN_PKT`.
  - In `WAIT_SOP`, an accepted beat is an SOP. Go to `IN_PKT` if tlast=0; stay in `WAIT_SOP` if tlast=1 (single-beat packet).
  - In `IN_PKT`, an accepted beat with tlast=1 returns the FSM to `WAIT_SOP`.
  - Non-accepted cycles never change state.
- **Port decode** (source field `f`, 8 bits), registered at the SOP:
  - One-hot on an even bit 0/2/4/6 → code 0/1/2/3.
  - One-hot on an odd bit → code 4.
  - Zero or multi-hot → code 5, and `bad_port_cnt` increments.
- **Timebase:**
  - `cnt_time` increments by 1 each cycle.
  - When `cnt_time == TICKS_PER_SEC`, the next value is 1. This gives exactly one terminal cycle per TICKS_PER_SEC cycles.
- **Boundary blanking:** `proc_port_3rd` must equal 7 in every cycle where `cnt_time == TICKS_PER_SEC`. An event due in that cycle is diverted to a 1-entry skid register and presented in the following cycle.
- **Skid rules,** for each cycle with new event N (or none) and skid S (or empty):
  - Next cycle is terminal: output 7. If S is empty, S←N. If S is full and N is present, N is dropped and `evt_drop_cnt` increments.
  - Next cycle is not terminal, S full: output S. Then S←N if N is present, else S empties.
  - Next cycle is not terminal, S empty: output N, or 7 if there is no N.
- Event ordering is always preserved; events are never duplicated.
- **Saturation:** both counters saturate at 32'hFFFFFFFF and never wrap.

## Timing
- **Reset** (asynchronous assert, synchronous-safe deassert handled externally). While `aresetn`=0:
  - `cnt_time`=0, `proc_port_3rd`=7, `bad_port_cnt`=0, `evt_drop_cnt`=0.
  - FSM in `WAIT_SOP`, skid empty.
- First clock after reset release: `cnt_time`=1.
- **Latency:**
  - SOP accepted at edge T: code is visible from T+1 for exactly one cycle.
  - If the event is deferred by the skid: visible from T+2.
  - `bad_port_cnt` updates at T+1.
- **Reset mid-packet:** the FSM returns to `WAIT_SOP`. The first accepted beat after release is treated as an SOP.
- Maximum event rate is one per cycle (back-to-back single-beat packets).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Basic decode:** release reset, then send 3-beat packets with source field 0x01, 0x04, 0x10, 0x40, 0x02 → `proc_port_3rd` shows 0, 1, 2, 3, 4, each for one cycle, one cycle after the SOP beat. Non-SOP beats produce 7.
- **Back-pressure and illegal source:**
  - Hold tready=0 for 5 cycles under tvalid=1 on a first beat → no event until the handshake.
  - A packet with source 0x00 and one with 0x03 → code 5 twice, `bad_port_cnt`=2.
- **Timebase:** use `TICKS_PER_SEC`=10 → after reset `cnt_time` runs 1..10,1..10. Value 10 appears once every 10 cycles.
- **Boundary deferral:** with `TICKS_PER_SEC`=10, place an SOP whose event would appear with `cnt_time`=10 → output 7 in that cycle and the code in the cycle with `cnt_time`=1. `evt_drop_cnt`=0.
- **Skid overflow:** with `TICKS_PER_SEC`=10, drive back-to-back single-beat SOPs continuously across two boundaries.
  - Every output cycle with `cnt_time`=10 shows 7.
  - The event stream stays in order.
  - `evt_drop_cnt` increments once at the second boundary.
- **Reset mid-packet:** assert `aresetn` during beat 2 of a 4-beat packet → all outputs at reset values. After release, the next accepted beat produces an event.

Source files
------------

// File: rtl/pkt_port_event_gen.sv
// pkt_port_event_gen: taps an AXI4-Stream, emits per-packet source-port event codes and a 1-second timebase.
module pkt_port_event_gen #(
    parameter int C_TUSER_WIDTH = 128,
    parameter int SRC_PORT_POS  = 16,
    parameter int TICKS_PER_SEC = 160000000
) (
    input  logic                     asclk,
    input  logic                     aresetn,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic [C_TUSER_WIDTH-1:0] s_axis_tuser,
    output logic [27:0]              cnt_time,
    output logic [2:0]               proc_port_3rd,
    output logic [31:0]              bad_port_cnt,
    output logic [31:0]              evt_drop_cnt
);
    localparam logic [27:0] TERM = 28'(TICKS_PER_SEC);
    localparam logic [2:0]  NONE = 3'd7;

    typedef enum logic {WAIT_SOP, IN_PKT} state_t;

    state_t      state_q, state_d;
    logic [27:0] cnt_q, cnt_d;
    logic [2:0]  proc_q, proc_d;
    logic [31:0] bad_q, bad_d, drop_q, drop_d;
    logic        skid_vld_q, skid_vld_d;
    logic [2:0]  skid_code_q, skid_code_d;
    logic        beat, sop, one_hot, term_next, drop;
    logic [7:0]  f;
    logic [2:0]  code;
    logic        unused_tuser;

    assign unused_tuser = ^s_axis_tuser;
    assign beat      = s_axis_tvalid & s_axis_tready;
    assign sop       = beat && state_q == WAIT_SOP;
    assign f         = s_axis_tuser[SRC_PORT_POS +: 8];
    assign one_hot   = (f != 8'd0) && ((f & (f - 8'd1)) == 8'd0);
    assign code      = !one_hot ? 3'd5 : |(f & 8'hAA) ? 3'd4 :
                       f[0] ? 3'd0 : f[2] ? 3'd1 : f[4] ? 3'd2 : 3'd3;
    assign cnt_d     = (cnt_q == TERM) ? 28'd1 : cnt_q + 28'd1;
    assign term_next = cnt_d == TERM;

    // SOP tracking: any accepted beat in WAIT_SOP starts a packet, tlast ends it
    always_comb begin
        state_d = state_q;
        if (beat)
            state_d = s_axis_tlast ? WAIT_SOP : IN_PKT;
    end

    // Event presentation: blank the terminal cycle, park one event in the skid, drop on overflow
    always_comb begin
        proc_d      = NONE;
        skid_vld_d  = skid_vld_q;
        skid_code_d = skid_code_q;
        drop        = 1'b0;
        if (term_next) begin
            if (!skid_vld_q) begin
                skid_vld_d  = sop;
                skid_code_d = code;
            end else begin
                drop = sop;
            end
        end else if (skid_vld_q) begin
            proc_d      = skid_code_q;
            skid_vld_d  = sop;
            skid_code_d = code;
        end else begin
            proc_d = sop ? code : NONE;
        end
    end

    // Saturating error counters
    always_comb begin
        bad_d  = (sop && !one_hot && bad_q != '1) ? bad_q + 32'd1 : bad_q;
        drop_d = (drop && drop_q != '1) ? drop_q + 32'd1 : drop_q;
    end

    // State and output registers
    always_ff @(posedge asclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= WAIT_SOP;
            cnt_q       <= '0;
            proc_q      <= NONE;
            bad_q       <= '0;
            drop_q      <= '0;
            skid_vld_q  <= 1'b0;
            skid_code_q <= NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            proc_q      <= proc_d;
            bad_q       <= bad_d;
            drop_q      <= drop_d;
            skid_vld_q  <= skid_vld_d;
            skid_code_q <= skid_code_d;
        end
    end

    assign cnt_time      = cnt_q;
    assign proc_port_3rd = proc_q;
    assign bad_port_cnt  = bad_q;
    assign evt_drop_cnt  = drop_q;
endmodule

// File: tb/tb_pkt_port_event_gen.sv
// tb_pkt_port_event_gen: directed stimulus with an event scoreboard and a timebase reference.
module tb_pkt_port_event_gen;
    localparam int TPS = 10;

    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic         tvalid = 1'b0, tready = 1'b0, tlast = 1'b0;
    logic [127:0] tuser = '0;
    logic [27:0]  cnt_time;
    logic [2:0]   proc;
    logic [31:0]  bad_cnt, drop_cnt;

    int checks = 0;
    int errors = 0;
    int tcnt = 0;
    logic [2:0] q[$];

    pkt_port_event_gen #(
        .C_TUSER_WIDTH(128),
        .SRC_PORT_POS(16),
        .TICKS_PER_SEC(TPS)
    ) dut (
        .asclk(clk),
        .aresetn(aresetn),
        .s_axis_tvalid(tvalid),
        .s_axis_tready(tready),
        .s_axis_tlast(tlast),
        .s_axis_tuser(tuser),
        .cnt_time(cnt_time),
        .proc_port_3rd(proc),
        .bad_port_cnt(bad_cnt),
        .evt_drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge aresetn)
        if (!aresetn) tcnt <= 0;
        else tcnt <= (tcnt == TPS) ? 1 : tcnt + 1;

    function automatic logic [2:0] code_of(input logic [7:0] f);
        int n = 0;
        int idx = 0;
        for (int i = 0; i < 8; i++)
            if (f[i]) begin
                n++;
                idx = i;
            end
        if (n != 1) return 3'd5;
        return (idx % 2) ? 3'd4 : 3'(idx / 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [7:0] f, input logic last, input bit push, input bit chk);
        tvalid = 1'b1;
        tready = 1'b1;
        tlast  = last;
        tuser  = 128'(f) << 16;
        if (push) q.push_back(code_of(f));
        @(posedge clk);
        #1;
        if (chk) check("sop_latency", 32'(proc), (tcnt == TPS) ? 32'd7 : 32'(code_of(f)));
        tvalid = 1'b0;
    endtask

    task automatic wait_cnt(input int v);
        for (int i = 0; i < 2 * TPS && tcnt != v; i++) begin
            @(posedge clk);
            #1;
        end
        check("wait_cnt", 32'(tcnt), 32'(v));
    endtask

    always @(negedge clk) begin
        check("cnt_time", 32'(cnt_time), 32'(tcnt));
        if (cnt_time == 28'(TPS)) check("blank_terminal", 32'(proc), 32'd7);
        if (proc !== 3'd7) begin
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_event: got %0d expected 7", proc);
            end
            if (q.size() != 0) check("event_order", 32'(proc), 32'(q.pop_front()));
        end
    end

    initial begin
        int nterm;
        int b;
        int nxt;
        logic [7:0] fields [5] = '{8'h01, 8'h04, 8'h10, 8'h40, 8'h02};
        repeat (3) @(posedge clk);
        #1;
        check("reset_proc", 32'(proc), 32'd7);
        check("reset_cnt", 32'(cnt_time), 32'd0);
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        check("first_cnt", 32'(cnt_time), 32'd1);
        check("reset_bad", bad_cnt, 32'd0);
        check("reset_drop", drop_cnt, 32'd0);

        for (int i = 0; i < 5; i++) begin
            beat(fields[i], 1'b0, 1'b1, 1'b1);
            beat(8'hFF, 1'b0, 1'b0, 1'b0);
            beat(8'h00, 1'b1, 1'b0, 1'b0);
        end

        tvalid = 1'b1;
        tready = 1'b0;
        tlast  = 1'b1;
        tuser  = 128'(8'h01) << 16;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("backpressure_idle", 32'(proc), 32'd7);
        end
        beat(8'h01, 1'b1, 1'b1, 1'b1);

        beat(8'h00, 1'b1, 1'b1, 1'b1);
        beat(8'h03, 1'b1, 1'b1, 1'b1);
        check("bad_port_cnt", bad_cnt, 32'd2);

        nterm = 0;
        for (int i = 0; i < 3 * TPS; i++) begin
            @(posedge clk);
            #1;
            if (cnt_time == 28'(TPS)) nterm++;
        end
        check("terminal_count", 32'(nterm), 32'd3);

        wait_cnt(TPS - 1);
        beat(8'h40, 1'b1, 1'b1, 1'b1);
        check("defer_cnt_term", 32'(cnt_time), 32'(TPS));
        @(posedge clk);
        #1;
        check("defer_cnt_wrap", 32'(cnt_time), 32'd1);
        check("defer_code", 32'(proc), 32'd3);
        check("defer_no_drop", drop_cnt, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        wait_cnt(1);
        b = 0;
        for (int i = 0; i < 20; i++) begin
            nxt = (tcnt == TPS) ? 1 : tcnt + 1;
            if (nxt == TPS) b++;
            beat(fields[i % 5], 1'b1, !(b >= 2 && nxt == TPS), 1'b0);
        end
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("overflow_drain", 32'(q.size()), 32'd0);
        check("evt_drop_cnt", drop_cnt, 32'd1);

        wait_cnt(2);
        beat(8'h10, 1'b0, 1'b1, 1'b1);
        tvalid = 1'b1;
        tready = 1'b1;
        tlast  = 1'b0;
        #6;
        aresetn = 1'b0;
        #1;
        tvalid = 1'b0;
        check("midrst_cnt", 32'(cnt_time), 32'd0);
        check("midrst_proc", 32'(proc), 32'd7);
        check("midrst_bad", bad_cnt, 32'd0);
        check("midrst_drop", drop_cnt, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        beat(8'h02, 1'b0, 1'b1, 1'b1);
        beat(8'h00, 1'b0, 1'b0, 1'b0);
        beat(8'h00, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("final_drain", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
